// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - UART line levels and receiver state encoding
package uart_rx_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_BIT  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the serial line, resets to idle level
module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= IDLE_BIT;
      dout <= IDLE_BIT;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled UART receiver with valid/read handshake and error flags
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stb,
  input  logic             i_uart_rx,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_frame_err,
  output logic             o_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  logic             rx_s;
  rx_state_t        state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             deliver, frame_bad;

  uart_rx_sync u_sync (
    .clk  (i_clk),
    .rst  (i_rst),
    .din  (i_uart_rx),
    .dout (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    if (i_stb) begin
      unique case (state)
        RX_IDLE: begin
          if (rx_s == START_BIT) begin
            state_n = RX_START;
            cnt_n   = '0;
          end
        end
        RX_START: begin
          // Re-check the line mid start bit to reject short glitches
          if (cnt == CNT_MID) begin
            cnt_n = '0;
            idx_n = '0;
            state_n = (rx_s == START_BIT) ? RX_DATA : RX_IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_END) begin
            shreg_n = {rx_s, shreg[WIDTH-1:1]};
            cnt_n   = '0;
            idx_n   = idx + 1'b1;
            if (idx == IDX_LAST) state_n = RX_STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_END) begin
            cnt_n = '0;
            if (rx_s == STOP_BIT) begin
              deliver = 1'b1;
              state_n = RX_IDLE;
            end else begin
              frame_bad = 1'b1;
              state_n   = RX_BREAK;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          // Wait out a held-low line so it cannot look like a new start bit
          if (rx_s == IDLE_BIT) state_n = RX_IDLE;
        end
        default: state_n = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (deliver) begin
        o_data      <= shreg;
        o_valid     <= 1'b1;
        o_frame_err <= 1'b0;
        // A read in the delivery cycle consumes the old word, so no overrun
        if (o_valid && !i_rd) o_overrun <= 1'b1;
        else if (o_valid)     o_overrun <= 1'b0;
      end else if (i_rd && o_valid) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end
      if (frame_bad) o_frame_err <= 1'b1;
    end
  end

  assign o_busy = (state != RX_IDLE);

endmodule
